// File: rtl/bht_counter_bank_64_pkg.sv
// Shared constants, counter-state encoding and saturating step helper for the
// branch-history counter bank.
package bht_counter_bank_64_pkg;

    localparam int unsigned BpEntries = 64;
    localparam int unsigned BpIdxW    = 6;

    // MSB of the counter is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        BpSnt = 2'b00,
        BpWnt = 2'b01,
        BpWt  = 2'b10,
        BpSt  = 2'b11
    } bp_ctr_e;

    localparam logic [1:0] BpInitState = BpWnt;

    // One saturating step: +1 on taken, -1 on not-taken, never wrapping.
    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != BpSt) nxt = cur + 2'd1;
        end else begin
            if (cur != BpSnt) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_counter_bank_64_sat.sv
// Single 2-bit saturating branch-history counter with synchronous reset/clear.
module bht_counter_bank_64_sat
    import bht_counter_bank_64_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       taken,
    input  logic [1:0] init,
    output logic [1:0] q
);

    logic [1:0] q_d;

    // Next state: reset and clear both reload init, otherwise step when enabled.
    always_comb begin
        q_d = q;
        if (reset || clear) begin
            q_d = init;
        end else if (en) begin
            q_d = sat_step(q, taken);
        end
    end

    // Counter state register.
    always_ff @(posedge clock) begin
        q <= q_d;
    end

endmodule

// File: rtl/bht_counter_bank_64.sv
// 64-entry bank of 2-bit saturating counters. Updates pass through one
// registered stage before being applied, keeping execute off the update path.
module bht_counter_bank_64
    import bht_counter_bank_64_pkg::*;
#(
    parameter int unsigned Entries   = BpEntries,
    parameter int unsigned IdxW      = BpIdxW,
    parameter logic [1:0]  InitState = BpInitState
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 upd_valid,
    input  logic [IdxW-1:0]      upd_index,
    input  logic                 upd_taken,
    output logic [2*Entries-1:0] counters_flat,
    output logic                 upd_pending
);

    logic            pend_q,  pend_d;
    logic [IdxW-1:0] idx_q,   idx_d;
    logic            taken_q, taken_d;
    logic [Entries-1:0] en_vec;

    // Stage next state: reset/clear drop any in-flight or arriving update.
    always_comb begin
        pend_d  = upd_valid;
        idx_d   = upd_index;
        taken_d = upd_taken;
        if (reset || clear) begin
            pend_d  = 1'b0;
            idx_d   = '0;
            taken_d = 1'b0;
        end
    end

    // Update stage registers.
    always_ff @(posedge clock) begin
        pend_q  <= pend_d;
        idx_q   <= idx_d;
        taken_q <= taken_d;
    end

    // 6:64 decode of the staged index into per-counter enables.
    always_comb begin
        en_vec = '0;
        if (pend_q) en_vec[idx_q] = 1'b1;
    end

    assign upd_pending = pend_q;

    for (genvar i = 0; i < Entries; i++) begin : g_ctr
        bht_counter_bank_64_sat u_ctr (
            .clock (clock),
            .reset (reset),
            .clear (clear),
            .en    (en_vec[i]),
            .taken (taken_q),
            .init  (InitState),
            .q     (counters_flat[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_bht_counter_bank_64.sv
// Self-checking bench for bht_counter_bank_64: directed scenarios plus a
// randomized update stream checked against a behavioural model.
module tb_bht_counter_bank_64;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear;
    logic         upd_valid;
    logic [5:0]   upd_index;
    logic         upd_taken;
    logic [127:0] counters_flat;
    logic         upd_pending;

    int checks   = 0;
    int failures = 0;

    // Reference model: counter values as plain integers, plus the one in-flight update.
    int m_ctr [64];
    bit m_pend;
    int m_idx;
    bit m_taken;

    bht_counter_bank_64 dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken),
        .counters_flat (counters_flat),
        .upd_pending   (upd_pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] field(input logic [127:0] v, input int i);
        return v[2*i +: 2];
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] v;
        for (int i = 0; i < 64; i++) v[2*i +: 2] = 2'(m_ctr[i]);
        return v;
    endfunction

    // Model of one rising edge with the inputs currently driven.
    task automatic model_edge();
        if (reset || clear) begin
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            m_pend = 0;
        end else begin
            if (m_pend) begin
                if (m_taken) m_ctr[m_idx] = (m_ctr[m_idx] == 3) ? 3 : m_ctr[m_idx] + 1;
                else         m_ctr[m_idx] = (m_ctr[m_idx] == 0) ? 0 : m_ctr[m_idx] - 1;
            end
            m_pend  = upd_valid;
            m_idx   = int'(upd_index);
            m_taken = upd_taken;
        end
    endtask

    // Drive one cycle, advance DUT and model, then compare away from the edge.
    task automatic cycle(input bit v, input int idx, input bit t, input bit clr, input bit rst);
        upd_valid = v;
        upd_index = 6'(idx);
        upd_taken = t;
        clear     = clr;
        reset     = rst;
        @(posedge clock);
        model_edge();
        #1;
        chk("model_flat", counters_flat, model_flat());
        chk("model_pending", 128'(upd_pending), 128'(m_pend));
    endtask

    logic [127:0] exp_v;
    logic [1:0]   steps [9];
    bit           rnd_clr;

    initial begin
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_pend = 0; m_idx = 0; m_taken = 0;
        upd_valid = 0; upd_index = 0; upd_taken = 0; clear = 0; reset = 1;

        // 1. Reset then idle: every field weakly not-taken.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) exp_v[2*i +: 2] = 2'b01;
        chk("reset_all_01", counters_flat, exp_v);
        chk("reset_pending0", 128'(upd_pending), 128'(0));

        // 2. Single update: pending after one edge, applied after two.
        cycle(1, 5, 1, 0, 0);
        chk("t2_pending1", 128'(upd_pending), 128'(1));
        chk("t2_f5_not_yet", 128'(field(counters_flat, 5)), 128'(2'b01));
        cycle(0, 0, 0, 0, 0);
        exp_v[11:10] = 2'b10;
        chk("t2_f5_10", counters_flat, exp_v);

        // 3. Saturation up then down on entry 63.
        steps = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 9; k++) begin
            cycle(k < 8, 63, k < 4, 0, 0);
            chk($sformatf("t3_f63_step%0d", k), 128'(field(counters_flat, 63)),
                128'(steps[k]));
        end

        // 4. Interleaved updates to entries 0 and 1 from a clean reset.
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) exp_v[2*i +: 2] = 2'b01;
        exp_v[1:0] = 2'b11;
        exp_v[3:2] = 2'b00;
        chk("t4_interleave", counters_flat, exp_v);

        // 5. Clear (then reset) discards the staged update and a same-edge request.
        cycle(1, 7, 1, 0, 0);
        cycle(1, 7, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);
        chk("t5_clear_f7", 128'(field(counters_flat, 7)), 128'(2'b01));
        chk("t5_clear_f0", 128'(field(counters_flat, 0)), 128'(2'b01));
        chk("t5_clear_pend", 128'(upd_pending), 128'(0));
        cycle(1, 7, 1, 0, 0);
        cycle(1, 7, 1, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk("t5_reset_f7", 128'(field(counters_flat, 7)), 128'(2'b01));
        chk("t5_reset_pend", 128'(upd_pending), 128'(0));

        // 6. Random stream, biased toward a few indices to hit saturation often.
        for (int k = 0; k < 1000; k++) begin
            rnd_clr = ($urandom_range(0, 63) == 0);
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 63)),
                  $urandom_range(0, 1) != 0, rnd_clr, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
